xil_bram_port_arb: RTL

Single-port access controller placed in front of one port of a true-dual-port block RAM. It clears the memory after reset, or on command, by sweeping it with one write per clock. Outside the sweep it round-robin arbitrates NREQ requesters onto the port and routes read data back to the requester that issued the read. It is the port-sharing and initialisation layer for the depth-cascaded BRAM wrappers.

---
 rtl/xil_bram_port_arb_pkg.sv | 21 ++
 rtl/xil_bram_port_arb_if.sv | 27 ++
 rtl/xil_bram_port_arb_rr_arb_n.sv | 52 +++++
 rtl/xil_bram_port_arb.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/xil_bram_port_arb_pkg.sv
// Shared types and helpers for the BRAM port arbiter: FSM state encoding and
// one-hot to index conversion.
package xil_bram_port_arb_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int MAX_REQ = 8;

  function automatic logic [2:0] onehot_idx(input logic [MAX_REQ-1:0] oh);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < MAX_REQ; i++) begin
      idx = idx | (3'(i) & {3{oh[i]}});
    end
    return idx;
  endfunction

endpackage

// File: rtl/xil_bram_port_arb_if.sv
// Requester-side bus of the BRAM port arbiter: packed requests, one-hot grant
// and the shared read-response channel.
interface xil_bram_port_arb_if #(
  parameter int ADR  = 10,
  parameter int DAT  = 18,
  parameter int NREQ = 4
);

  logic [NREQ-1:0]     req_vld;
  logic [NREQ-1:0]     req_wr;
  logic [NREQ*ADR-1:0] req_adr;
  logic [NREQ*DAT-1:0] req_wda;
  logic [NREQ-1:0]     req_gnt;
  logic [NREQ-1:0]     rsp_vld;
  logic [DAT-1:0]      rsp_dat;

  modport master (
    output req_vld, req_wr, req_adr, req_wda,
    input  req_gnt, rsp_vld, rsp_dat
  );

  modport slave (
    input  req_vld, req_wr, req_adr, req_wda,
    output req_gnt, rsp_vld, rsp_dat
  );

endinterface

// File: rtl/xil_bram_port_arb_rr_arb_n.sv
// NREQ-way round-robin arbiter: one-hot grant searched upward from ptr, ptr
// moves past the winner whenever a grant is taken.
module xil_rr_arb_n
  import xil_bram_port_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] gnt
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   ptr_r;
  logic [PW-1:0]   ptr_nxt_s;
  logic [NREQ-1:0] gnt_s;
  logic            found_s;
  int              k_s;

  // Priority search starting at ptr, wrapping past NREQ-1.
  always_comb begin
    int j;
    j       = 0;
    gnt_s   = {NREQ{1'b0}};
    found_s = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      j        = (int'(ptr_r) + i) % NREQ;
      gnt_s[j] = req[j] & ~found_s;
      found_s  = found_s | req[j];
    end
  end

  assign k_s       = int'(onehot_idx(MAX_REQ'(gnt_s))) + 1;
  assign ptr_nxt_s = (k_s >= NREQ) ? {PW{1'b0}} : PW'(k_s);

  // Priority pointer; held when nothing is granted.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_r <= {PW{1'b0}};
    end else if (advance) begin
      ptr_r <= ptr_nxt_s;
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign gnt = gnt_s;

endmodule

// File: rtl/xil_bram_port_arb.sv
// Shares one BRAM port among NREQ requesters and clears the memory with a
// one-write-per-clock sweep after reset or on clr.
module xil_bram_port_arb
  import xil_bram_port_arb_pkg::*;
#(
  parameter int             ADR      = 10,
  parameter int             DAT      = 18,
  parameter int             NREQ     = 4,
  parameter int             RDL      = 2,
  parameter bit             INIT_EN  = 1'b1,
  parameter logic [DAT-1:0] INIT_VAL = {DAT{1'b0}}
) (
  input  logic                clk,
  input  logic                rst,
  xil_bram_port_arb_if.slave  bus,
  input  logic                clr,
  output logic [ADR-1:0]      mem_adr,
  output logic                mem_wen,
  output logic [DAT-1:0]      mem_wda,
  output logic                mem_ren,
  input  logic [DAT-1:0]      mem_rda,
  output logic                init_busy,
  output logic                init_done
);

  localparam logic [ADR-1:0] LAST_ADR = {ADR{1'b1}};

  state_e          state_r;
  logic [ADR-1:0]  cnt_r;
  logic [ADR-1:0]  mem_adr_r;
  logic [DAT-1:0]  mem_wda_r;
  logic            mem_wen_r;
  logic            mem_ren_r;
  logic            init_done_r;
  logic            gnt_en_s;
  logic [NREQ-1:0] gnt_s;
  logic [ADR-1:0]  sel_adr_s;
  logic [DAT-1:0]  sel_wda_s;
  logic            sel_wr_s;
  logic            rd_acc_s;
  logic [RDL:0]    pipe_vld_r;
  logic [NREQ-1:0] pipe_id_r [RDL+1];

  // The cycle carrying the last sweep write is already RUN but still grant-free.
  assign gnt_en_s = (state_r == ST_RUN) && !init_done_r && !clr;

  xil_rr_arb_n #(.NREQ(NREQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (bus.req_vld & {NREQ{gnt_en_s}}),
    .advance (|gnt_s),
    .gnt     (gnt_s)
  );

  // One-hot mux of the granted requester's fields.
  always_comb begin
    sel_adr_s = {ADR{1'b0}};
    sel_wda_s = {DAT{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      sel_adr_s = sel_adr_s | (bus.req_adr[i*ADR +: ADR] & {ADR{gnt_s[i]}});
      sel_wda_s = sel_wda_s | (bus.req_wda[i*DAT +: DAT] & {DAT{gnt_s[i]}});
    end
  end

  assign sel_wr_s = |(bus.req_wr & gnt_s);
  assign rd_acc_s = (|gnt_s) && !sel_wr_s;

  // INIT/RUN state machine driving the registered BRAM port.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= INIT_EN ? ST_INIT : ST_RUN;
      cnt_r       <= {ADR{1'b0}};
      mem_adr_r   <= {ADR{1'b0}};
      mem_wda_r   <= {DAT{1'b0}};
      mem_wen_r   <= 1'b0;
      mem_ren_r   <= 1'b0;
      init_done_r <= 1'b0;
    end else begin
      case (state_r)
        ST_INIT: begin
          mem_wen_r   <= 1'b1;
          mem_ren_r   <= 1'b0;
          mem_adr_r   <= cnt_r;
          mem_wda_r   <= INIT_VAL;
          init_done_r <= (cnt_r == LAST_ADR);
          if (cnt_r == LAST_ADR) begin
            state_r <= ST_RUN;
            cnt_r   <= {ADR{1'b0}};
          end else begin
            state_r <= ST_INIT;
            cnt_r   <= cnt_r + ADR'(1'b1);
          end
        end
        ST_RUN: begin
          init_done_r <= 1'b0;
          state_r     <= clr ? ST_INIT : ST_RUN;
          if (|gnt_s) begin
            mem_wen_r <= sel_wr_s;
            mem_ren_r <= !sel_wr_s;
            mem_adr_r <= sel_adr_s;
            mem_wda_r <= sel_wda_s;
          end else begin
            mem_wen_r <= 1'b0;
            mem_ren_r <= 1'b0;
          end
        end
        default: begin
          state_r     <= ST_RUN;
          cnt_r       <= {ADR{1'b0}};
          mem_wen_r   <= 1'b0;
          mem_ren_r   <= 1'b0;
          init_done_r <= 1'b0;
        end
      endcase
    end
  end

  // Read-response pipe: tail lines up with valid BRAM read data.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pipe_vld_r <= {(RDL+1){1'b0}};
      for (int i = 0; i <= RDL; i++) begin
        pipe_id_r[i] <= {NREQ{1'b0}};
      end
    end else begin
      pipe_vld_r   <= {pipe_vld_r[RDL-1:0], rd_acc_s};
      pipe_id_r[0] <= gnt_s;
      for (int i = 1; i <= RDL; i++) begin
        pipe_id_r[i] <= pipe_id_r[i-1];
      end
    end
  end

  assign bus.req_gnt = gnt_s;
  assign bus.rsp_vld = pipe_vld_r[RDL] ? pipe_id_r[RDL] : {NREQ{1'b0}};
  assign bus.rsp_dat = mem_rda;
  assign mem_adr     = mem_adr_r;
  assign mem_wda     = mem_wda_r;
  assign mem_wen     = mem_wen_r;
  assign mem_ren     = mem_ren_r;
  assign init_busy   = (state_r == ST_INIT);
  assign init_done   = init_done_r;

endmodule
